// File: rtl/datapath_pkg.sv
// Shared datapath widths and register-file types.
// Used by reg_file_wb and reg_scoreboard.
package datapath_pkg;

  localparam int DATA_WIDTH = 4;
  localparam int ADDR_WIDTH = 2;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;
  typedef logic [NUM_REGS-1:0]   reg_mask_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard for the register file.
// Issue sets a bit, write-back clears it; issue wins on a tie.
module reg_scoreboard
  import datapath_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      iss_en,
  input  reg_addr_t iss_addr,
  input  logic      wb_en,
  input  reg_addr_t wb_addr,
  input  reg_addr_t ra_addr,
  input  reg_addr_t rb_addr,
  output logic      pend_a,
  output logic      pend_b
);

  reg_mask_t pend_q;
  reg_mask_t pend_d;

  // Next pending vector: clear on write-back, then set on issue.
  always_comb begin
    pend_d = pend_q;
    if (wb_en) begin
      pend_d[wb_addr] = 1'b0;
    end
    if (iss_en) begin
      pend_d[iss_addr] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  // Pending state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pend_a = pend_q[ra_addr];
  assign pend_b = pend_q[rb_addr];

endmodule

// File: rtl/reg_file_wb.sv
// Write-back register file: 2 read ports, 1 write port, stall flag.
// Optional REG_BYPASS_EN forwards write_data to matching read ports.
module reg_file_wb
  import datapath_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      wb_en,
  input  reg_addr_t wb_addr,
  input  reg_data_t write_data,
  input  logic      iss_en,
  input  reg_addr_t iss_addr,
  input  reg_addr_t ra_addr,
  input  reg_addr_t rb_addr,
  output reg_data_t ra_data,
  output reg_data_t rb_data,
  output logic      stall
);

  reg_data_t regs_q [NUM_REGS];
  logic      wb_live;
  logic      zero_a;
  logic      zero_b;
  logic      hit_a;
  logic      hit_b;
  logic      pend_a;
  logic      pend_b;

  assign wb_live = wb_en && (wb_addr != '0);

  // Register array; address 0 is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_live) begin
      regs_q[wb_addr] <= write_data;
    end
  end

  reg_scoreboard u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .ra_addr  (ra_addr),
    .rb_addr  (rb_addr),
    .pend_a   (pend_a),
    .pend_b   (pend_b)
  );

  // Read-port selection: zero register, bypass hit, or stored value.
  always_comb begin
    zero_a = (ra_addr == '0);
    zero_b = (rb_addr == '0);
`ifdef REG_BYPASS_EN
    hit_a  = wb_live && (ra_addr == wb_addr);
    hit_b  = wb_live && (rb_addr == wb_addr);
`else
    hit_a  = 1'b0;
    hit_b  = 1'b0;
`endif
    ra_data = regs_q[ra_addr];
    rb_data = regs_q[rb_addr];
    if (hit_a) ra_data = write_data;
    if (hit_b) rb_data = write_data;
    if (zero_a) ra_data = '0;
    if (zero_b) rb_data = '0;
    stall = (pend_a && !zero_a && !hit_a) ||
            (pend_b && !zero_b && !hit_b);
  end

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed-vector bench for reg_file_wb.
// Expectations follow REG_BYPASS_EN when it is defined.
module tb_reg_file_wb;
  import datapath_pkg::*;

  logic      clk;
  logic      rst_n;
  logic      wb_en;
  reg_addr_t wb_addr;
  reg_data_t write_data;
  logic      iss_en;
  reg_addr_t iss_addr;
  reg_addr_t ra_addr;
  reg_addr_t rb_addr;
  reg_data_t ra_data;
  reg_data_t rb_data;
  logic      stall;

  int n_vec;
  int n_bad;

  reg_file_wb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .write_data (write_data),
    .iss_en     (iss_en),
    .iss_addr   (iss_addr),
    .ra_addr    (ra_addr),
    .rb_addr    (rb_addr),
    .ra_data    (ra_data),
    .rb_data    (rb_data),
    .stall      (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_en  = 1'b0;
    iss_en = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    wb_en = 1'b0; wb_addr = '0; write_data = '0;
    iss_en = 1'b0; iss_addr = '0;
    ra_addr = 2'd1; rb_addr = 2'd2;
    #1;
    chk("rst_ra", 8'(ra_data), 8'h0);
    chk("rst_rb", 8'(rb_data), 8'h0);
    chk("rst_stall", 8'(stall), 8'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // plain write to reg 1
    wb_en = 1'b1; wb_addr = 2'd1; write_data = 4'h9;
    tick();
    idle();
    ra_addr = 2'd1;
    #1;
    chk("wr_r1", 8'(ra_data), 8'h9);

    // write to reg 0 dropped
    wb_en = 1'b1; wb_addr = 2'd0; write_data = 4'hF;
    tick();
    idle();
    ra_addr = 2'd0; rb_addr = 2'd0;
    #1;
    chk("r0_ra", 8'(ra_data), 8'h0);
    chk("r0_rb", 8'(rb_data), 8'h0);
    chk("r0_stall", 8'(stall), 8'h0);

    // issue to reg 0 never stalls
    iss_en = 1'b1; iss_addr = 2'd0;
    tick();
    idle();
    #1;
    chk("r0_iss", 8'(stall), 8'h0);

    // issue then write-back on reg 3
    iss_en = 1'b1; iss_addr = 2'd3;
    tick();
    idle();
    ra_addr = 2'd3; rb_addr = 2'd0;
    #1;
    chk("iss3_stall", 8'(stall), 8'h1);
    wb_en = 1'b1; wb_addr = 2'd3; write_data = 4'h5;
    #1;
`ifdef REG_BYPASS_EN
    chk("wb3_pre_ra", 8'(ra_data), 8'h5);
    chk("wb3_pre_st", 8'(stall), 8'h0);
`else
    chk("wb3_pre_ra", 8'(ra_data), 8'h0);
    chk("wb3_pre_st", 8'(stall), 8'h1);
`endif
    tick();
    idle();
    #1;
    chk("wb3_ra", 8'(ra_data), 8'h5);
    chk("wb3_stall", 8'(stall), 8'h0);

    // same edge, same address: issue wins
    iss_en = 1'b1; iss_addr = 2'd2;
    wb_en = 1'b1; wb_addr = 2'd2; write_data = 4'h6;
    tick();
    idle();
    ra_addr = 2'd0; rb_addr = 2'd2;
    #1;
    chk("tie_rb", 8'(rb_data), 8'h6);
    chk("tie_stall", 8'(stall), 8'h1);

    // same edge, different addresses
    iss_en = 1'b1; iss_addr = 2'd3;
    wb_en = 1'b1; wb_addr = 2'd1; write_data = 4'h7;
    tick();
    idle();
    ra_addr = 2'd1; rb_addr = 2'd0;
    #1;
    chk("diff_ra", 8'(ra_data), 8'h7);
    chk("diff_st_a", 8'(stall), 8'h0);
    rb_addr = 2'd3;
    #1;
    chk("diff_st_b", 8'(stall), 8'h1);

    // async reset mid-cycle with reg2=A pending
    iss_en = 1'b1; iss_addr = 2'd2;
    wb_en = 1'b1; wb_addr = 2'd2; write_data = 4'hA;
    tick();
    idle();
    ra_addr = 2'd2; rb_addr = 2'd0;
    #1;
    chk("pre_rst_ra", 8'(ra_data), 8'hA);
    chk("pre_rst_st", 8'(stall), 8'h1);
    rst_n = 1'b0;
    #1;
    chk("arst_ra", 8'(ra_data), 8'h0);
    chk("arst_stall", 8'(stall), 8'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // bypass scenario on reg 1
    wb_en = 1'b1; wb_addr = 2'd1; write_data = 4'h3;
    tick();
    idle();
    iss_en = 1'b1; iss_addr = 2'd1;
    tick();
    idle();
    ra_addr = 2'd1; rb_addr = 2'd1;
    #1;
    chk("byp_pend", 8'(stall), 8'h1);
    wb_en = 1'b1; wb_addr = 2'd1; write_data = 4'hC;
    #1;
`ifdef REG_BYPASS_EN
    chk("byp_ra", 8'(ra_data), 8'hC);
    chk("byp_rb", 8'(rb_data), 8'hC);
    chk("byp_stall", 8'(stall), 8'h0);
`else
    chk("byp_ra", 8'(ra_data), 8'h3);
    chk("byp_rb", 8'(rb_data), 8'h3);
    chk("byp_stall", 8'(stall), 8'h1);
`endif
    tick();
    idle();
    #1;
    chk("post_ra", 8'(ra_data), 8'hC);
    chk("post_stall", 8'(stall), 8'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
